// File: rtl/rv32i_pkg.sv
// Shared RV32I constants, opcode encodings and fetch-stage types.
// FETCH_MISALIGN_CHECK_EN adds the HALT fetch state.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {StRun, StDrain, StHalt} fetch_state_e;
`else
  typedef enum logic [1:0] {StRun, StDrain} fetch_state_e;
`endif

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32i_fetch_fifo.sv
// Synchronous FIFO holding {pc, instruction} pairs for the fetch stage.
// Flush empties it in one cycle and wins over a same-cycle push or pop.
module rv32i_fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_push = i_push && ((r_count != (PtrW+1)'(DEPTH)) || w_pop);

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count <= r_count + (PtrW+1)'(w_push) - (PtrW+1)'(w_pop);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (PtrW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch: owns the PC, issues imem requests, buffers responses for the decoder.
// Define FETCH_MISALIGN_CHECK_EN to halt on a misaligned redirect target.
module rv32i_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        fetch_misaligned
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    r_state;
  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_resp_pc;
  logic [CntW-1:0] r_outstanding;
  logic [CntW-1:0] r_drop_cnt;
  logic            r_req_en;

  logic [2*XLEN-1:0] w_fifo_data;
  logic [CntW-1:0]   w_fifo_count;
  logic              w_fifo_empty;
  logic              w_unused_fifo_full;
  logic              w_halted;
  logic              w_misaligned_redirect;
  logic              w_redirect;
  logic              w_pop;
  logic              w_accept;
  logic              w_drop_resp;
  logic              w_push;
  logic              w_credit;
  logic [CntW:0]     w_occupancy;
  logic [CntW-1:0]   w_inflight;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misaligned;
  assign w_halted              = (r_state == StHalt);
  assign w_misaligned_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fetch_misaligned      = r_misaligned;
`else
  logic w_unused_redirect_lsb;
  assign w_unused_redirect_lsb = ^redirect_pc[1:0];
  assign w_halted              = 1'b0;
  assign w_misaligned_redirect = 1'b0;
  assign fetch_misaligned      = 1'b0;
`endif

  assign w_redirect  = redirect_valid && !w_halted;
  assign w_pop       = !w_fifo_empty && inst_ready && !w_redirect;
  // Slots are reserved at request time; a same-cycle pop frees one for full throughput.
  assign w_occupancy = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign w_credit    = (w_occupancy - (CntW+1)'(w_pop)) < (CntW+1)'(FIFO_DEPTH);

  assign imem_req_valid = r_req_en && !w_redirect && !w_halted && w_credit;
  assign imem_req_addr  = r_fetch_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_drop_resp    = (r_drop_cnt != '0) || w_halted;
  assign w_push         = imem_resp_valid && !w_drop_resp && !w_redirect;
  assign w_inflight     = r_outstanding - CntW'(imem_resp_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StRun;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_req_en      <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      r_misaligned  <= 1'b0;
`endif
    end else begin
      r_req_en <= 1'b1;
      if (w_redirect) begin
        // Everything still in flight belongs to the old path and is dropped on return.
        r_fetch_pc    <= word_align(redirect_pc);
        r_resp_pc     <= word_align(redirect_pc);
        r_outstanding <= w_inflight;
        r_drop_cnt    <= w_inflight;
        r_state       <= (w_inflight != '0) ? StDrain : StRun;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (w_misaligned_redirect) begin
          r_state      <= StHalt;
          r_misaligned <= 1'b1;
        end
`endif
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
        r_outstanding <= w_inflight + CntW'(w_accept);
        if (imem_resp_valid) begin
          if (r_drop_cnt != '0) begin
            r_drop_cnt <= r_drop_cnt - CntW'(1);
          end else if (!w_halted) begin
            r_resp_pc <= r_resp_pc + 32'd4;
          end
        end
        if ((r_state == StDrain) && imem_resp_valid && (r_drop_cnt == CntW'(1))) begin
          r_state <= StRun;
        end
      end
    end
  end

  rv32i_fetch_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({r_resp_pc, imem_resp_data}),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .o_data  (w_fifo_data),
    .o_full  (w_unused_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign inst_valid  = !w_fifo_empty;
  assign instruction = w_fifo_empty ? NOP_INSN : w_fifo_data[XLEN-1:0];
  assign inst_pc     = w_fifo_empty ? RESET_PC : w_fifo_data[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_rv32i_fetch.sv
// Scoreboard bench for rv32i_fetch: a memory model answers requests in order and the
// expected instruction stream is derived from program order plus redirect targets.
module tb_rv32i_fetch;

  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic        fetch_misaligned;

  always #5 clk = ~clk;

  rv32i_fetch #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .instruction      (instruction),
    .inst_pc          (inst_pc),
    .fetch_misaligned (fetch_misaligned)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } item_t;

  int          checks = 0;
  int          failures = 0;
  int          delivered = 0;
  item_t       exp_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] next_pc = RST_PC;
  bit          tb_halted = 1'b0;
  bit          acc_s = 1'b0;
  bit          resp_s = 1'b0;
  logic [31:0] acc_addr_s = '0;
  int          p_ready = 100;
  int          p_resp = 100;
  int          p_inst = 100;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic top_up();
    item_t it;
    while (!tb_halted && exp_q.size() < 8) begin
      it.pc   = next_pc;
      it.data = mem_word(next_pc);
      exp_q.push_back(it);
      next_pc += 32'd4;
    end
  endtask

  task automatic set_resp(input bit on);
    imem_resp_valid = on && (mem_q.size() > 0);
    imem_resp_data  = imem_resp_valid ? mem_word(mem_q[0]) : $urandom;
  endtask

  // Advance one cycle: retire last cycle's handshakes into the memory model, then drive.
  task automatic tick();
    @(posedge clk);
    #1;
    if (acc_s) mem_q.push_back(acc_addr_s);
    if (resp_s) void'(mem_q.pop_front());
    redirect_valid = 1'b0;
    imem_req_ready = ($urandom_range(99) < p_ready);
    inst_ready     = ($urandom_range(99) < p_inst);
    set_resp($urandom_range(99) < p_resp);
    top_up();
  endtask

  task automatic redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    exp_q.delete();
    next_pc = {tgt[31:2], 2'b00};
`ifdef FETCH_MISALIGN_CHECK_EN
    if (tgt[1:0] != 2'b00) tb_halted = 1'b1;
`endif
    top_up();
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_req_ready  = 1'b0;
    inst_ready      = 1'b0;
    mem_q.delete();
    exp_q.delete();
    tb_halted = 1'b0;
    next_pc   = RST_PC;
    repeat (2) @(negedge clk);
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_req_addr", imem_req_addr, RST_PC);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_instruction", instruction, NOP);
    check("rst_inst_pc", inst_pc, RST_PC);
    check("rst_misaligned", {31'd0, fetch_misaligned}, 32'd0);
    #1;
    rst_n = 1'b1;
    top_up();
    #1;
    check("req_valid_before_first_edge", {31'd0, imem_req_valid}, 32'd0);
    tick();
    @(negedge clk);
    check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_req_addr, RST_PC);
  endtask

  // Monitor: samples at the falling edge, scores every consumed instruction.
  always @(negedge clk) begin
    item_t e;
    acc_s  = 1'b0;
    resp_s = 1'b0;
    if (rst_n) begin
      acc_s      = imem_req_valid && imem_req_ready;
      acc_addr_s = imem_req_addr;
      resp_s     = imem_resp_valid;
      checks++;
      if (mem_q.size() > DEPTH) begin
        failures++;
        $display("FAIL outstanding_bound: got %0d in flight, limit %0d", mem_q.size(), DEPTH);
      end
      if (acc_s) check("req_addr_aligned", {30'd0, imem_req_addr[1:0]}, 32'd0);
      if (inst_valid && inst_ready && !redirect_valid) begin
        delivered++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_inst: got pc %h, none expected", inst_pc);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e.pc);
          check("instruction", instruction, e.data);
        end
      end
    end
  end

  initial begin
    int d0;
    #1;
    do_reset();

    // Ideal memory and decoder: one instruction per cycle once started.
    repeat (10) tick();
    d0 = delivered;
    repeat (30) tick();
    check("throughput_30_cycles", 32'(delivered - d0), 32'd30);

    // Decoder stall: buffer fills, no extra requests, nothing lost.
    p_inst = 0;
    repeat (5) tick();
    check("stall_inst_valid", {31'd0, inst_valid}, 32'd1);
    check("stall_no_inflight", 32'(mem_q.size()), 32'd0);
    p_inst = 100;
    repeat (10) tick();

    // Redirect with DEPTH fetches in flight: both stale responses dropped.
    p_resp = 0;
    repeat (6) tick();
    check("two_in_flight", 32'(mem_q.size()), 32'(DEPTH));
    redirect(32'h0000_0100);
    #1;
    check("no_req_on_redirect", {31'd0, imem_req_valid}, 32'd0);
    tick();
    check("redirect_inst_valid_low", {31'd0, inst_valid}, 32'd0);
    check("redirect_req_addr", imem_req_addr, 32'h0000_0100);
    p_resp = 100;
    repeat (20) tick();

    // Redirect coinciding with a response and a decoder pop.
    repeat (6) tick();
    check("same_cycle_setup", {29'd0, imem_resp_valid, inst_valid, inst_ready}, 32'd7);
    redirect(32'h0000_0200);
    repeat (15) tick();

    // PC wraps from 0xFFFF_FFFC to 0.
    tick();
    redirect(32'hFFFF_FFF8);
    repeat (15) tick();

    // Random traffic with occasional redirects.
    p_ready = 70;
    p_resp  = 60;
    p_inst  = 70;
    for (int i = 0; i < 800; i++) begin
      tick();
      if ($urandom_range(99) < 5) begin
`ifdef FETCH_MISALIGN_CHECK_EN
        redirect($urandom & 32'hFFFF_FFFC);
`else
        redirect($urandom);
`endif
      end
    end

    // Reset in the middle of traffic.
    p_ready = 100;
    p_resp  = 100;
    p_inst  = 100;
    do_reset();
    repeat (10) tick();

    // Misaligned redirect target.
    tick();
    redirect(32'h0000_0102);
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 8; i++) begin
      tick();
      check("halt_misaligned", {31'd0, fetch_misaligned}, 32'd1);
      check("halt_req_valid", {31'd0, imem_req_valid}, 32'd0);
      check("halt_inst_valid", {31'd0, inst_valid}, 32'd0);
    end
    do_reset();
    repeat (10) tick();
`else
    tick();
    check("misaligned_req_addr", imem_req_addr, 32'h0000_0100);
    repeat (10) tick();
    check("misaligned_flag_tied", {31'd0, fetch_misaligned}, 32'd0);
`endif

    checks++;
    if (delivered < 200) begin
      failures++;
      $display("FAIL liveness: got %0d instructions delivered, need at least 200", delivered);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32i_fetch.md
# rv32i_fetch

Instruction fetch stage for the RV32I core, sitting directly upstream of the decoder. Owns the PC, issues word requests to instruction memory over a valid/ready handshake, buffers in-order responses in a small FIFO, and presents {instruction, pc} pairs to the decoder with valid/ready flow control. Taken jal/jalr/branch redirects flush buffered and in-flight fetches and restart at the new PC.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_resp_valid  in  1  response word valid; in order, ≥1 cycle after acceptance, never back-pressured
- imem_resp_data  in  32  fetched instruction word
- redirect_valid  in  1  taken jump/branch; flush and restart
- redirect_pc  in  32  new fetch address
- inst_valid  out  1  instruction/inst_pc valid to decoder
- inst_ready  in  1  decoder consumes this cycle
- instruction  out  32  instruction word
- inst_pc  out  32  address of instruction
- fetch_misaligned  out  1  sticky misaligned-target flag (see Configuration)

## Operation
- Registers: fetch_pc, outstanding (0..FIFO_DEPTH), drop_cnt (0..FIFO_DEPTH), FIFO of {pc, word}.
- Request: imem_req_valid = !drop_pending_block && (outstanding + fifo_count < FIFO_DEPTH) && !halted. Accept = valid && ready: fetch_pc += 4 (mod 2^32, wraps 0xFFFF_FFFC→0), outstanding++.
- Request PC for each outstanding fetch kept in a parallel tag queue inside the FIFO (pc pushed with data).
- Response: if drop_cnt>0, discard and drop_cnt--; else push {pc, data}. Either way outstanding--.
- Output: inst_valid = FIFO non-empty; pop on inst_valid && inst_ready. Outputs show FIFO head (no bypass).
- Redirect (highest priority): FIFO cleared, fetch_pc ← {redirect_pc[31:2],2'b00}, drop_cnt ← outstanding minus any response arriving the same cycle (plus any request accepted the same cycle, which is cancelled-by-drop), no pop credited, no request issued that cycle.
- States: RUN (normal), DRAIN (drop_cnt>0; requests allowed, new responses discarded until drop_cnt=0), HALT (misaligned, macro only). RUN→DRAIN on redirect with in-flight fetches; DRAIN→RUN when drop_cnt reaches 0.
- Simultaneous push and pop on full FIFO permitted; count unchanged.

## Timing
- Reset: imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, instruction=32'h0000_0013 (NOP), inst_pc=RESET_PC, fetch_misaligned=0; FIFO empty, counters 0.
- First request the cycle after rst_n deasserts.
- Latency: response cycle N → inst_valid at N+1.
- Redirect in cycle N → first request to redirect_pc in N+1; inst_valid=0 from N+1 until new data arrives.
- Back-to-back throughput 1 instruction/cycle with 1-cycle memory and FIFO_DEPTH≥2.
- Reset mid-transaction: all state cleared; memory responses to pre-reset requests must not arrive after reset (system guarantee).

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: redirect_pc[1:0]≠0 sets fetch_misaligned (sticky until reset), enters HALT: no requests, FIFO flushed, in-flight responses dropped, inst_valid=0.
- Undefined: redirect_pc[1:0] silently ignored; fetch_misaligned tied 0; no HALT state.

## Structure
- rv32i_pkg: XLEN=32, NOP_INSN=32'h0000_0013, RESET_PC default, opcode constants shared with decoder.
- Sub-module rv32i_fetch_fifo: parameterised sync FIFO (width 64, depth FIFO_DEPTH), push/pop/flush, full/empty/count.

## Test plan
- Reset, memory ready always, 1-cycle response of addr-as-data -> requests 0x0,0x4,0x8…; inst_pc/instruction match, one per cycle after 2-cycle startup.
- inst_ready=0 for 5 cycles -> at most FIFO_DEPTH buffered + 0 extra requests outstanding beyond DEPTH; no loss, order preserved on release.
- Redirect to 0x100 with 2 fetches in flight -> both responses discarded, next inst_pc=0x100.
- Redirect in same cycle as response and pop -> response dropped, no duplicate, drop_cnt correct, next inst_pc=redirect target.
- fetch_pc at 0xFFFF_FFFC -> next request 0x0000_0000.
- With FETCH_MISALIGN_CHECK_EN, redirect_pc=0x102 -> fetch_misaligned=1, imem_req_valid=0, inst_valid=0 until reset; without macro, fetch at 0x100.
